stream_width_down: RTL and testbench

STREAM_WIDTH_DOWN -- requirements
Module: stream_width_down

---
 rtl/stream_width_down_if.sv | 25 ++
 rtl/stream_width_down.sv | 116 +++++++++++
 tb/tb_stream_width_down.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_width_down_if.sv
// ============================================================================
// if_axi_stream : valid/ready byte stream with sop/eop/mod/err/ctl sideband
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
);
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;

  modport sink   (input  val, sop, eop, err, dat, mod, ctl, output rdy);
  modport source (output val, sop, eop, err, dat, mod, ctl, input  rdy);
endinterface

`default_nettype wire

// File: rtl/stream_width_down.sv
// ============================================================================
// stream_width_down : splits each wide input beat into RATIO narrow sub-beats
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_width_down #(
  parameter int IN_DAT_BYTS  = 64,
  parameter int OUT_DAT_BYTS = 8,
  parameter int CTL_BITS     = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_if,
  if_axi_stream.source  o_if
);

  localparam int c_RATIO        = IN_DAT_BYTS / OUT_DAT_BYTS;
  localparam int c_IN_BITS      = IN_DAT_BYTS * 8;
  localparam int c_OUT_BITS     = OUT_DAT_BYTS * 8;
  localparam int c_IN_MOD_BITS  = (IN_DAT_BYTS > 1) ? $clog2(IN_DAT_BYTS) : 1;
  localparam int c_OUT_MOD_BITS = (OUT_DAT_BYTS > 1) ? $clog2(OUT_DAT_BYTS) : 1;
  localparam int c_IDX_BITS     = $clog2(c_RATIO);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [c_IN_BITS-1:0]      r_dat;
  logic [c_OUT_MOD_BITS-1:0] r_mod_out;
  logic [CTL_BITS-1:0]       r_ctl;
  logic                      r_sop;
  logic                      r_eop;
  logic                      r_err;
  logic [c_IDX_BITS-1:0]     r_idx;
  logic [c_IDX_BITS-1:0]     r_last;

  logic                      w_hold;
  logic                      w_on_last;
  logic                      w_in_rdy;
  logic                      w_in_xfer;
  logic                      w_out_xfer;
  logic [c_IDX_BITS-1:0]     w_last_ld;
  logic [c_OUT_MOD_BITS-1:0] w_mod_ld;
  logic [c_IN_MOD_BITS-1:0]  w_in_mod;
  logic [c_OUT_BITS-1:0]     w_sub [c_RATIO];

  assign w_hold     = (r_state == ST_HOLD);
  assign w_on_last  = (r_idx == r_last);
  assign w_in_rdy   = !w_hold || (o_if.rdy && w_on_last);
  assign w_in_xfer  = i_if.val && w_in_rdy;
  assign w_out_xfer = w_hold && o_if.rdy;
  assign w_in_mod   = i_if.mod;

  // Store the index of the final sub-beat rather than the count, so the
  // "last" test is a plain equality and no extra bit is needed for RATIO.
  always_comb begin
    w_last_ld = c_IDX_BITS'(c_RATIO - 1);
    if (i_if.eop && (w_in_mod != '0)) begin
      w_last_ld = c_IDX_BITS'((int'(w_in_mod) - 1) / OUT_DAT_BYTS);
    end
  end

  assign w_mod_ld = c_OUT_MOD_BITS'(int'(w_in_mod) % OUT_DAT_BYTS);

  for (genvar g = 0; g < c_RATIO; g++) begin : g_sub
    assign w_sub[g] = r_dat[g*c_OUT_BITS +: c_OUT_BITS];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_EMPTY;
      r_idx     <= '0;
      r_last    <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_mod_out <= '0;
      r_ctl     <= '0;
    end else if (w_in_xfer) begin
      // Covers both a load from EMPTY and the same-cycle reload on the last sub-beat.
      r_state   <= ST_HOLD;
      r_idx     <= '0;
      r_last    <= w_last_ld;
      r_sop     <= i_if.sop;
      r_eop     <= i_if.eop;
      r_err     <= i_if.err;
      r_dat     <= i_if.dat;
      r_mod_out <= w_mod_ld;
      r_ctl     <= i_if.ctl;
    end else if (w_out_xfer) begin
      if (w_on_last) begin
        r_state <= ST_EMPTY;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign i_if.rdy = w_in_rdy;

  assign o_if.val = w_hold;
  assign o_if.dat = w_sub[r_idx];
  assign o_if.sop = w_hold && r_sop && (r_idx == '0);
  assign o_if.eop = w_hold && r_eop && w_on_last;
  assign o_if.mod = (r_eop && w_on_last) ? r_mod_out : '0;
  assign o_if.ctl = r_ctl;
  assign o_if.err = w_hold && r_err;

endmodule

`default_nettype wire

// File: tb/tb_stream_width_down.sv
// ============================================================================
// tb_stream_width_down : directed self-checking bench, 16-byte in / 4-byte out
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_width_down;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  if_axi_stream #(.DAT_BYTS(16), .CTL_BITS(8)) in_if ();
  if_axi_stream #(.DAT_BYTS(4),  .CTL_BITS(8)) out_if ();

  stream_width_down #(
    .IN_DAT_BYTS  (16),
    .OUT_DAT_BYTS (4),
    .CTL_BITS     (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_if  (in_if),
    .o_if  (out_if)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat16(input logic [7:0] base);
    logic [127:0] v;
    for (int b = 0; b < 16; b++) v[b*8 +: 8] = base + 8'(b);
    return v;
  endfunction

  function automatic logic [31:0] word4(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [7:0] base, input logic s,
                          input logic e, input logic [3:0] m, input logic [7:0] c,
                          input logic er);
    in_if.val = v;
    in_if.dat = beat16(base);
    in_if.sop = s;
    in_if.eop = e;
    in_if.mod = m;
    in_if.ctl = c;
    in_if.err = er;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_in(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    out_if.rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (out_if.val !== 1'b0 || out_if.sop !== 1'b0 || out_if.eop !== 1'b0 || out_if.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: val/sop/eop/err=%b%b%b%b required 0000",
               out_if.val, out_if.sop, out_if.eop, out_if.err);
    end
    checks++;
    if (in_if.rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_rdy: got %b required 1", in_if.rdy);
    end
  endtask

  task automatic test_full_beat();
    drive_in(1'b1, 8'h00, 1'b1, 1'b1, 4'd0, 8'hA5, 1'b0);
    step();
    in_if.val = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_if.val !== 1'b1 || out_if.dat !== word4(8'(j*4)) ||
          out_if.sop !== (j == 0) || out_if.eop !== (j == 3) ||
          out_if.mod !== 2'd0 || out_if.ctl !== 8'hA5) begin
        failures++;
        $display("FAIL full_beat_%0d: val=%b dat=%h sop=%b eop=%b mod=%0d ctl=%h required 1 %h %b %b 0 a5",
                 j, out_if.val, out_if.dat, out_if.sop, out_if.eop, out_if.mod, out_if.ctl,
                 word4(8'(j*4)), (j == 0), (j == 3));
      end
      step();
    end
    checks++;
    if (out_if.val !== 1'b0) begin
      failures++;
      $display("FAIL full_beat_drain: val=%b required 0", out_if.val);
    end
  endtask

  task automatic test_partial(input logic [3:0] m, input logic [7:0] base, input logic [1:0] exp_mod);
    drive_in(1'b1, base, 1'b1, 1'b1, m, 8'h3C, 1'b1);
    step();
    in_if.val = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (out_if.val !== 1'b1 || out_if.dat !== word4(base + 8'(j*4)) ||
          out_if.eop !== (j == 1) || out_if.mod !== ((j == 1) ? exp_mod : 2'd0) ||
          out_if.err !== 1'b1 || in_if.rdy !== (j == 1)) begin
        failures++;
        $display("FAIL partial_m%0d_%0d: val=%b dat=%h eop=%b mod=%0d err=%b in_rdy=%b required 1 %h %b %0d 1 %b",
                 m, j, out_if.val, out_if.dat, out_if.eop, out_if.mod, out_if.err, in_if.rdy,
                 word4(base + 8'(j*4)), (j == 1), (j == 1) ? exp_mod : 2'd0, (j == 1));
      end
      step();
    end
    checks++;
    if (out_if.val !== 1'b0) begin
      failures++;
      $display("FAIL partial_m%0d_drain: val=%b required 0", m, out_if.val);
    end
  endtask

  task automatic test_backpressure();
    drive_in(1'b1, 8'h60, 1'b1, 1'b1, 4'd0, 8'h11, 1'b0);
    step();
    in_if.val = 1'b0;
    step();
    out_if.rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_if.val !== 1'b1 || out_if.dat !== 32'h67666564 || out_if.sop !== 1'b0 ||
          out_if.eop !== 1'b0 || in_if.rdy !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: val=%b dat=%h sop=%b eop=%b in_rdy=%b required 1 67666564 0 0 0",
                 k, out_if.val, out_if.dat, out_if.sop, out_if.eop, in_if.rdy);
      end
      step();
    end
    out_if.rdy = 1'b1;
    for (int j = 1; j < 4; j++) begin
      checks++;
      if (out_if.val !== 1'b1 || out_if.dat !== word4(8'h60 + 8'(j*4)) || out_if.eop !== (j == 3)) begin
        failures++;
        $display("FAIL release_%0d: val=%b dat=%h eop=%b required 1 %h %b",
                 j, out_if.val, out_if.dat, out_if.eop, word4(8'h60 + 8'(j*4)), (j == 3));
      end
      step();
    end
    checks++;
    if (out_if.val !== 1'b0) begin
      failures++;
      $display("FAIL release_drain: val=%b required 0", out_if.val);
    end
  endtask

  task automatic test_back_to_back();
    int   k;
    logic xfer;
    logic [7:0] exp_base;
    k = 0;
    drive_in(1'b1, 8'h80, 1'b1, 1'b0, 4'd5, 8'h77, 1'b0);
    for (int j = 0; j < 12; j++) begin
      xfer = in_if.val && in_if.rdy;
      step();
      if (xfer) begin
        k++;
        if (k < 3) drive_in(1'b1, 8'h80 + 8'(k*16), 1'b0, (k == 2), 4'd0, 8'h77, 1'b0);
        else       in_if.val = 1'b0;
      end
      exp_base = 8'h80 + 8'((j / 4) * 16) + 8'((j % 4) * 4);
      checks++;
      if (out_if.val !== 1'b1 || out_if.dat !== word4(exp_base) ||
          out_if.sop !== (j == 0) || out_if.eop !== (j == 11)) begin
        failures++;
        $display("FAIL b2b_%0d: val=%b dat=%h sop=%b eop=%b required 1 %h %b %b",
                 j, out_if.val, out_if.dat, out_if.sop, out_if.eop, word4(exp_base), (j == 0), (j == 11));
      end
    end
    in_if.val = 1'b0;
    step();
    checks++;
    if (out_if.val !== 1'b0 || k !== 3) begin
      failures++;
      $display("FAIL b2b_drain: val=%b accepted=%0d required 0 3", out_if.val, k);
    end
  endtask

  task automatic test_mid_reset();
    drive_in(1'b1, 8'hC0, 1'b1, 1'b1, 4'd0, 8'h22, 1'b1);
    step();
    in_if.val = 1'b0;
    step();
    step();
    checks++;
    if (out_if.dat !== 32'hCBCAC9C8) begin
      failures++;
      $display("FAIL mid_reset_idx2: dat=%h required cbcac9c8", out_if.dat);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_if.val !== 1'b0 || out_if.err !== 1'b0 || in_if.rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_flush: val=%b err=%b in_rdy=%b required 0 0 1",
               out_if.val, out_if.err, in_if.rdy);
    end
    drive_in(1'b1, 8'hD0, 1'b1, 1'b1, 4'd0, 8'h33, 1'b0);
    step();
    in_if.val = 1'b0;
    checks++;
    if (out_if.val !== 1'b1 || out_if.dat !== 32'hD3D2D1D0 || out_if.sop !== 1'b1 || out_if.ctl !== 8'h33) begin
      failures++;
      $display("FAIL mid_reset_reload: val=%b dat=%h sop=%b ctl=%h required 1 d3d2d1d0 1 33",
               out_if.val, out_if.dat, out_if.sop, out_if.ctl);
    end
    step();
    step();
    step();
    step();
  endtask

  task automatic test_idle();
    drive_in(1'b0, 8'hE0, 1'b1, 1'b1, 4'd0, 8'h44, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_if.val !== 1'b0) begin
        failures++;
        $display("FAIL idle_%0d: val=%b required 0", c, out_if.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial(4'd6, 8'h20, 2'd2);
    test_partial(4'd8, 8'h40, 2'd0);
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
